// File: rtl/rob_multi_commit_pkg.sv
// Shared types for the multi-commit reorder buffer: per-entry control state and flag encoding.
// Wide, width-parameterised fields (dst, value, new_pc) live in separate arrays in the top.
`ifndef ROB_DEBUG_EN
`define ROB_DEBUG_EN 0
`endif

package rob_multi_commit_pkg;

  typedef logic [3:0] nzcv_t;

  typedef struct packed {
    logic  valid;
    logic  ready;
    logic  set_nzcv;
    logic  mispred;
    nzcv_t nzcv;
  } rob_entry_t;

  // Bits needed to hold a count in 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_multi_commit_select.sv
// Commit selector: counts consecutive valid&ready entries from head, capped at COMMIT_WIDTH,
// stopping after (and including) the first mispredicted one. Purely combinational, no backpressure.
module rob_commit_select
  import rob_multi_commit_pkg::*;
#(
  parameter  int COMMIT_WIDTH = 2,
  localparam int CNT_W        = cnt_width(COMMIT_WIDTH),
  localparam int SLOT_W       = slot_width(COMMIT_WIDTH)
) (
  input  logic [COMMIT_WIDTH-1:0] rot_valid,
  input  logic [COMMIT_WIDTH-1:0] rot_ready,
  input  logic [COMMIT_WIDTH-1:0] rot_mispred,
  output logic [CNT_W-1:0]        commit_cnt,
  output logic                    mispred_found,
  output logic [SLOT_W-1:0]       mispred_slot
);

  logic stop;

  always_comb begin
    commit_cnt    = '0;
    mispred_found = 1'b0;
    mispred_slot  = '0;
    stop          = 1'b0;
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      if (!stop && rot_valid[s] && rot_ready[s]) begin
        commit_cnt = commit_cnt + CNT_W'(1);
        if (rot_mispred[s]) begin
          mispred_found = 1'b1;
          mispred_slot  = SLOT_W'(s);
          stop          = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: 1 alloc/cycle, NUM_WB writebacks/cycle, up to COMMIT_WIDTH in-order retirements;
// commit outputs registered one edge after ready; alloc backpressured via out_reg_ready (count==DEPTH).
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int COMMIT_WIDTH = 2,
  parameter  int NUM_WB       = 2,
  parameter  int GPR_SIZE     = 64,
  parameter  int GPR_IDX_SIZE = 5,
  localparam int ROB_IDX_SIZE = $clog2(DEPTH)
) (
  input  logic                               in_clk,
  input  logic                               in_rst_n,
  input  logic                               in_reg_done,
  input  logic [GPR_IDX_SIZE-1:0]            in_reg_dst,
  input  logic                               in_reg_set_nzcv,
  output logic                               out_reg_ready,
  output logic [ROB_IDX_SIZE-1:0]            out_reg_next_rob_index,
  input  logic [NUM_WB-1:0]                  in_fu_done,
  input  logic [NUM_WB*ROB_IDX_SIZE-1:0]     in_fu_dst_rob_index,
  input  logic [NUM_WB*GPR_SIZE-1:0]         in_fu_value,
  input  logic [NUM_WB*4-1:0]                in_fu_nzcv,
  input  logic [NUM_WB-1:0]                  in_fu_is_mispred,
  input  logic [NUM_WB*GPR_SIZE-1:0]         in_fu_new_pc,
  output logic [COMMIT_WIDTH-1:0]            out_reg_commit_done,
  output logic [COMMIT_WIDTH*GPR_IDX_SIZE-1:0] out_reg_commit_index,
  output logic [COMMIT_WIDTH*GPR_SIZE-1:0]   out_reg_commit_value,
  output logic [COMMIT_WIDTH*ROB_IDX_SIZE-1:0] out_reg_commit_rob_index,
  output logic                               out_reg_set_nzcv,
  output logic [3:0]                         out_reg_nzcv,
  output logic                               out_fetch_mispredict,
  output logic [GPR_SIZE-1:0]                out_fetch_new_PC,
  output logic [ROB_IDX_SIZE:0]              out_rob_count
);

  localparam int CNT_W  = cnt_width(COMMIT_WIDTH);
  localparam int SLOT_W = slot_width(COMMIT_WIDTH);
  localparam int RW     = ROB_IDX_SIZE;

  rob_entry_t              ctrl     [DEPTH];
  logic [GPR_IDX_SIZE-1:0] dst_q    [DEPTH];
  logic [GPR_SIZE-1:0]     value_q  [DEPTH];
  logic [GPR_SIZE-1:0]     new_pc_q [DEPTH];

  logic [RW-1:0] head;
  logic [RW-1:0] tail;
  logic [RW:0]   count;

  logic [RW-1:0]           rot_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] rot_valid;
  logic [COMMIT_WIDTH-1:0] rot_ready;
  logic [COMMIT_WIDTH-1:0] rot_mispred;
  logic [CNT_W-1:0]        sel_cnt;
  logic                    flush;
  logic [SLOT_W-1:0]       mis_slot;

  logic [RW-1:0] wb_idx [NUM_WB];
  logic          wb_hit [NUM_WB];
  logic          alloc_fire;
  logic [RW-1:0] head_nxt;
  logic          c_set_nzcv;
  nzcv_t         c_nzcv;

  // Oldest COMMIT_WIDTH entries, viewed from head; DEPTH >= COMMIT_WIDTH so no index repeats.
  always_comb begin
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      rot_idx[s]     = head + RW'(s);
      rot_valid[s]   = ctrl[rot_idx[s]].valid;
      rot_ready[s]   = ctrl[rot_idx[s]].ready;
      rot_mispred[s] = ctrl[rot_idx[s]].mispred;
    end
  end

  rob_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_select (
    .rot_valid     (rot_valid),
    .rot_ready     (rot_ready),
    .rot_mispred   (rot_mispred),
    .commit_cnt    (sel_cnt),
    .mispred_found (flush),
    .mispred_slot  (mis_slot)
  );

  always_comb begin
    for (int c = 0; c < NUM_WB; c++) begin
      wb_idx[c] = in_fu_dst_rob_index[c*RW +: RW];
      wb_hit[c] = in_fu_done[c] && ctrl[wb_idx[c]].valid && !flush;
    end
  end

  assign alloc_fire             = in_reg_done && (count != (RW+1)'(DEPTH)) && !flush;
  assign head_nxt               = head + RW'(sel_cnt);
  assign out_reg_ready          = (count != (RW+1)'(DEPTH));
  assign out_reg_next_rob_index = tail;
  assign out_rob_count          = count;

  // Flags come from the youngest committing entry that writes them.
  always_comb begin
    c_set_nzcv = 1'b0;
    c_nzcv     = '0;
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      if ((CNT_W'(s) < sel_cnt) && ctrl[rot_idx[s]].set_nzcv) begin
        c_set_nzcv = 1'b1;
        c_nzcv     = ctrl[rot_idx[s]].nzcv;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl[i] <= '0;
      end
      head                     <= '0;
      tail                     <= '0;
      count                    <= '0;
      out_reg_commit_done      <= '0;
      out_reg_commit_index     <= '0;
      out_reg_commit_value     <= '0;
      out_reg_commit_rob_index <= '0;
      out_reg_set_nzcv         <= 1'b0;
      out_reg_nzcv             <= '0;
      out_fetch_mispredict     <= 1'b0;
      out_fetch_new_PC         <= '0;
    end else begin
      // Ascending channel order: the highest channel targeting an entry wins.
      for (int c = 0; c < NUM_WB; c++) begin
        if (wb_hit[c]) begin
          ctrl[wb_idx[c]].ready   <= 1'b1;
          ctrl[wb_idx[c]].nzcv    <= in_fu_nzcv[c*4 +: 4];
          ctrl[wb_idx[c]].mispred <= in_fu_is_mispred[c];
        end
      end

      for (int s = 0; s < COMMIT_WIDTH; s++) begin
        if (CNT_W'(s) < sel_cnt) begin
          ctrl[rot_idx[s]].valid <= 1'b0;
          ctrl[rot_idx[s]].ready <= 1'b0;
          out_reg_commit_done[s]                                  <= 1'b1;
          out_reg_commit_index[s*GPR_IDX_SIZE +: GPR_IDX_SIZE]    <= dst_q[rot_idx[s]];
          out_reg_commit_value[s*GPR_SIZE +: GPR_SIZE]            <= value_q[rot_idx[s]];
          out_reg_commit_rob_index[s*RW +: RW]                    <= rot_idx[s];
        end else begin
          out_reg_commit_done[s]                                  <= 1'b0;
          out_reg_commit_index[s*GPR_IDX_SIZE +: GPR_IDX_SIZE]    <= '0;
          out_reg_commit_value[s*GPR_SIZE +: GPR_SIZE]            <= '0;
          out_reg_commit_rob_index[s*RW +: RW]                    <= '0;
        end
      end

      out_reg_set_nzcv     <= c_set_nzcv;
      out_reg_nzcv         <= c_nzcv;
      out_fetch_mispredict <= flush;
      head                 <= head_nxt;

      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          ctrl[i].valid <= 1'b0;
          ctrl[i].ready <= 1'b0;
        end
        out_fetch_new_PC <= new_pc_q[rot_idx[mis_slot]];
        tail             <= head_nxt;
        count            <= '0;
      end else begin
        if (alloc_fire) begin
          ctrl[tail] <= '{valid: 1'b1, ready: 1'b0, set_nzcv: in_reg_set_nzcv,
                          mispred: 1'b0, nzcv: '0};
          tail       <= tail + RW'(1);
        end
        count <= count + (RW+1)'(alloc_fire) - (RW+1)'(sel_cnt);
      end
    end
  end

  // Payload storage needs no reset: it is only read behind a valid/ready bit.
  always_ff @(posedge in_clk) begin
    for (int c = 0; c < NUM_WB; c++) begin
      if (wb_hit[c]) begin
        value_q[wb_idx[c]]  <= in_fu_value[c*GPR_SIZE +: GPR_SIZE];
        new_pc_q[wb_idx[c]] <= in_fu_new_pc[c*GPR_SIZE +: GPR_SIZE];
      end
    end
    if (alloc_fire) begin
      dst_q[tail] <= in_reg_dst;
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: directed scenarios plus random traffic, all checked against a queue model.
module tb_rob_multi_commit;

  localparam int DEPTH = 16;
  localparam int CW    = 2;
  localparam int NW    = 2;
  localparam int RW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            reg_done;
  logic [4:0]      reg_dst;
  logic            reg_set;
  logic            fu_done [NW];
  logic [RW-1:0]   fu_idx  [NW];
  logic [63:0]     fu_val  [NW];
  logic [3:0]      fu_nz   [NW];
  logic            fu_mis  [NW];
  logic [63:0]     fu_pc   [NW];

  logic [NW-1:0]     fu_done_v;
  logic [NW*RW-1:0]  fu_idx_v;
  logic [NW*64-1:0]  fu_val_v;
  logic [NW*4-1:0]   fu_nz_v;
  logic [NW-1:0]     fu_mis_v;
  logic [NW*64-1:0]  fu_pc_v;

  always_comb begin
    for (int c = 0; c < NW; c++) begin
      fu_done_v[c]         = fu_done[c];
      fu_idx_v[c*RW +: RW] = fu_idx[c];
      fu_val_v[c*64 +: 64] = fu_val[c];
      fu_nz_v[c*4 +: 4]    = fu_nz[c];
      fu_mis_v[c]          = fu_mis[c];
      fu_pc_v[c*64 +: 64]  = fu_pc[c];
    end
  end

  logic            rdy;
  logic [RW-1:0]   next_idx;
  logic [CW-1:0]   c_done;
  logic [CW*5-1:0] c_index;
  logic [CW*64-1:0] c_value;
  logic [CW*RW-1:0] c_ridx;
  logic            set_nzcv;
  logic [3:0]      nzcv;
  logic            mispredict;
  logic [63:0]     new_pc;
  logic [RW:0]     count;

  rob_multi_commit dut (
    .in_clk                   (clk),
    .in_rst_n                 (rst_n),
    .in_reg_done              (reg_done),
    .in_reg_dst               (reg_dst),
    .in_reg_set_nzcv          (reg_set),
    .out_reg_ready            (rdy),
    .out_reg_next_rob_index   (next_idx),
    .in_fu_done               (fu_done_v),
    .in_fu_dst_rob_index      (fu_idx_v),
    .in_fu_value              (fu_val_v),
    .in_fu_nzcv               (fu_nz_v),
    .in_fu_is_mispred         (fu_mis_v),
    .in_fu_new_pc             (fu_pc_v),
    .out_reg_commit_done      (c_done),
    .out_reg_commit_index     (c_index),
    .out_reg_commit_value     (c_value),
    .out_reg_commit_rob_index (c_ridx),
    .out_reg_set_nzcv         (set_nzcv),
    .out_reg_nzcv             (nzcv),
    .out_fetch_mispredict     (mispredict),
    .out_fetch_new_PC         (new_pc),
    .out_rob_count            (count)
  );

  // Reference model: program-order list of in-flight instructions.
  typedef struct {
    int          idx;
    logic [4:0]  dst;
    bit          set;
    bit          rdy;
    logic [63:0] val;
    logic [3:0]  nz;
    bit          mis;
    logic [63:0] pc;
  } ment_t;

  ment_t       mq[$];
  int          m_next;
  logic [63:0] m_pc;

  bit          e_done [CW];
  logic [4:0]  e_dst  [CW];
  logic [63:0] e_val  [CW];
  int          e_ridx [CW];
  bit          e_setn;
  logic [3:0]  e_nz;
  bit          e_mis;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_next = 0;
    m_pc   = '0;
  endtask

  task automatic model_step();
    int cnt0;
    int k;
    int last_idx;
    ment_t n;
    cnt0 = mq.size();
    k = 0;
    last_idx = 0;
    e_mis = 0;
    e_setn = 0;
    e_nz = '0;
    for (int s = 0; s < CW; s++) e_done[s] = 0;
    while (!e_mis && k < CW && k < mq.size() && mq[k].rdy) begin
      e_done[k] = 1;
      e_dst[k]  = mq[k].dst;
      e_val[k]  = mq[k].val;
      e_ridx[k] = mq[k].idx;
      if (mq[k].set) begin
        e_setn = 1;
        e_nz   = mq[k].nz;
      end
      if (mq[k].mis) begin
        e_mis    = 1;
        m_pc     = mq[k].pc;
        last_idx = mq[k].idx;
      end
      k++;
    end
    for (int s = 0; s < k; s++) void'(mq.pop_front());
    if (e_mis) begin
      mq.delete();
      m_next = (last_idx + 1) % DEPTH;
    end else begin
      for (int c = 0; c < NW; c++) begin
        if (fu_done[c]) begin
          foreach (mq[j]) begin
            if (mq[j].idx == int'(fu_idx[c])) begin
              mq[j].rdy = 1;
              mq[j].val = fu_val[c];
              mq[j].nz  = fu_nz[c];
              mq[j].mis = fu_mis[c];
              mq[j].pc  = fu_pc[c];
            end
          end
        end
      end
      if (reg_done && cnt0 < DEPTH) begin
        n = '{idx: m_next, dst: reg_dst, set: reg_set, rdy: 0, val: '0, nz: '0, mis: 0, pc: '0};
        mq.push_back(n);
        m_next = (m_next + 1) % DEPTH;
      end
    end
  endtask

  task automatic check_outputs();
    for (int s = 0; s < CW; s++) begin
      chk($sformatf("done%0d", s), c_done[s], e_done[s]);
      if (e_done[s]) begin
        chk($sformatf("dst%0d", s), c_index[s*5 +: 5], e_dst[s]);
        chk($sformatf("val%0d", s), c_value[s*64 +: 64], e_val[s]);
        chk($sformatf("ridx%0d", s), c_ridx[s*RW +: RW], e_ridx[s]);
      end
    end
    chk("set_nzcv", set_nzcv, e_setn);
    if (e_setn) chk("nzcv", nzcv, e_nz);
    chk("mispredict", mispredict, e_mis);
    chk("new_pc", new_pc, m_pc);
    chk("count", count, mq.size());
    chk("ready", rdy, mq.size() != DEPTH);
    chk("next_idx", next_idx, m_next);
  endtask

  task automatic idle();
    reg_done = 0;
    reg_dst  = '0;
    reg_set  = 0;
    for (int c = 0; c < NW; c++) begin
      fu_done[c] = 0;
      fu_idx[c]  = '0;
      fu_val[c]  = '0;
      fu_nz[c]   = '0;
      fu_mis[c]  = 0;
      fu_pc[c]   = '0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    idle();
  endtask

  task automatic alloc(input logic [4:0] d, input bit s);
    reg_done = 1;
    reg_dst  = d;
    reg_set  = s;
    cycle();
  endtask

  task automatic set_wb(input int c, input int idx, input logic [63:0] v, input logic [3:0] nz,
                        input bit mis, input logic [63:0] pc);
    fu_done[c] = 1;
    fu_idx[c]  = RW'(idx);
    fu_val[c]  = v;
    fu_nz[c]   = nz;
    fu_mis[c]  = mis;
    fu_pc[c]   = pc;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    do_reset();

    // Reset state
    chk("rst_done", c_done, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", rdy, 1);
    chk("rst_next", next_idx, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_pc", new_pc, 0);

    // Out-of-order writebacks, in-order two-wide commit
    alloc(5'd1, 0);
    alloc(5'd2, 0);
    alloc(5'd3, 0);
    set_wb(0, 2, 64'd30, 4'h0, 0, '0);
    cycle();
    set_wb(0, 0, 64'd10, 4'h0, 0, '0);
    set_wb(1, 1, 64'd20, 4'h0, 0, '0);
    cycle();
    cycle();
    chk("t1_done", c_done, 2'b11);
    chk("t1_dst0", c_index[4:0], 1);
    chk("t1_val0", c_value[63:0], 10);
    chk("t1_dst1", c_index[9:5], 2);
    chk("t1_val1", c_value[127:64], 20);
    cycle();
    chk("t1b_done", c_done, 2'b01);
    chk("t1b_val", c_value[63:0], 30);
    chk("t1b_count", count, 0);

    // Full buffer, ignored 17th request, wrap of the tail
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(5'(i), 0);
    chk("full_ready", rdy, 0);
    alloc(5'd31, 0);
    chk("full_count", count, 16);
    set_wb(0, 0, 64'hA, 4'h0, 0, '0);
    set_wb(1, 1, 64'hB, 4'h0, 0, '0);
    cycle();
    chk("full_still", rdy, 0);
    cycle();
    chk("freed_ready", rdy, 1);
    chk("freed_next", next_idx, 0);
    chk("freed_count", count, 14);

    // Same-cycle writebacks to one entry: highest channel wins
    do_reset();
    for (int i = 0; i < 6; i++) alloc(5'(i + 8), 0);
    set_wb(0, 0, 64'h100, 4'h0, 0, '0);
    set_wb(1, 1, 64'h101, 4'h0, 0, '0);
    cycle();
    set_wb(0, 2, 64'h102, 4'h0, 0, '0);
    set_wb(1, 3, 64'h103, 4'h0, 0, '0);
    cycle();
    set_wb(0, 4, 64'h104, 4'h0, 0, '0);
    cycle();
    cycle();
    chk("dup_pre_count", count, 1);
    set_wb(0, 5, 64'd7, 4'h0, 0, '0);
    set_wb(1, 5, 64'd9, 4'h0, 0, '0);
    cycle();
    cycle();
    chk("dup_done", c_done, 2'b01);
    chk("dup_ridx", c_ridx[RW-1:0], 5);
    chk("dup_val", c_value[63:0], 9);

    // Mispredict at commit flushes younger entries and drops a same-cycle allocation
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 0);
    set_wb(0, 2, 64'h22, 4'h0, 0, '0);
    set_wb(1, 3, 64'h33, 4'h0, 0, '0);
    cycle();
    set_wb(0, 0, 64'h11, 4'h0, 0, '0);
    set_wb(1, 1, 64'h44, 4'h0, 1, 64'h40);
    cycle();
    reg_done = 1;
    reg_dst  = 5'd20;
    cycle();
    chk("mis_done", c_done, 2'b11);
    chk("mis_pulse", mispredict, 1);
    chk("mis_pc", new_pc, 64'h40);
    chk("mis_count", count, 0);
    chk("mis_next", next_idx, 2);
    cycle();
    chk("mis_pulse_end", mispredict, 0);
    chk("mis_pc_hold", new_pc, 64'h40);
    chk("mis_no_more", c_done, 0);
    cycle();
    chk("mis_no_more2", c_done, 0);

    // Flags from the youngest flag-writing committer
    do_reset();
    alloc(5'd1, 1);
    alloc(5'd2, 1);
    set_wb(0, 0, 64'h1, 4'b1000, 0, '0);
    set_wb(1, 1, 64'h2, 4'b0100, 0, '0);
    cycle();
    cycle();
    chk("nz_set", set_nzcv, 1);
    chk("nz_val", nzcv, 4'b0100);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reg_done = ($urandom_range(3) != 0);
      reg_dst  = 5'($urandom);
      reg_set  = $urandom_range(1);
      for (int c = 0; c < NW; c++) begin
        if ($urandom_range(1) == 1) begin
          int t;
          t = (mq.size() > 0 && $urandom_range(7) != 0) ? mq[$urandom_range(mq.size() - 1)].idx
                                                         : int'($urandom_range(DEPTH - 1));
          set_wb(c, t, {$urandom, $urandom}, 4'($urandom), ($urandom_range(24) == 0),
                 {$urandom, $urandom});
        end
      end
      cycle();
    end

    // Asynchronous reset in the middle of a commit
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 1);
    set_wb(0, 4, 64'h4, 4'h1, 0, '0);
    set_wb(1, 3, 64'h3, 4'h2, 0, '0);
    cycle();
    set_wb(0, 2, 64'h2, 4'h3, 0, '0);
    set_wb(1, 1, 64'h1, 4'h4, 0, '0);
    cycle();
    set_wb(0, 0, 64'h7, 4'h5, 0, '0);
    cycle();
    cycle();
    chk("ar_pre_done", c_done, 2'b11);
    #2;
    rst_n = 0;
    #1;
    chk("ar_done", c_done, 0);
    chk("ar_index", c_index, 0);
    chk("ar_value", c_value[63:0], 0);
    chk("ar_ridx", c_ridx, 0);
    chk("ar_setn", set_nzcv, 0);
    chk("ar_nzcv", nzcv, 0);
    chk("ar_count", count, 0);
    chk("ar_next", next_idx, 0);
    chk("ar_mis", mispredict, 0);
    model_reset();
    #3;
    rst_n = 1;
    repeat (4) cycle();
    chk("ar_after_done", c_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
